// File: rtl/axi4lite_reg_slice.sv
// axi4lite_reg_slice: fully registered AXI4-Lite slice, one two-entry skid buffer per channel
module axi4lite_reg_slice_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [W-1:0] src_data,
  output logic         dst_valid,
  input  logic         dst_ready,
  output logic [W-1:0] dst_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept, load, skid_n;
  assign accept = src_valid && src_ready;
  assign load   = !dst_valid || dst_ready;
  assign skid_n = !load && (skid_valid || accept);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dst_valid  <= 1'b0;
      skid_valid <= 1'b0;
      src_ready  <= 1'b0;
    end else begin
      dst_valid  <= load ? (skid_valid || accept) : 1'b1;
      skid_valid <= skid_n;
      src_ready  <= !skid_n;
    end
  end
  // payload registers carry no reset; they are only observed while valid
  always_ff @(posedge clk) begin
    if (load) dst_data <= skid_valid ? skid_data : src_data;
    if (!load && accept) skid_data <= src_data;
  end
endmodule

module axi4lite_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [2:0]              S_AXI_awprot,
  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  output logic [1:0]              S_AXI_bresp,
  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [2:0]              S_AXI_arprot,
  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_awaddr,
  output logic [2:0]              M_AXI_awprot,
  output logic                    M_AXI_awvalid,
  input  logic                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0] M_AXI_wstrb,
  output logic                    M_AXI_wvalid,
  input  logic                    M_AXI_wready,
  input  logic [1:0]              M_AXI_bresp,
  input  logic                    M_AXI_bvalid,
  output logic                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]   M_AXI_araddr,
  output logic [2:0]              M_AXI_arprot,
  output logic                    M_AXI_arvalid,
  input  logic                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]   M_AXI_rdata,
  input  logic [1:0]              M_AXI_rresp,
  input  logic                    M_AXI_rvalid,
  output logic                    M_AXI_rready
);
  localparam int AP = ADDR_WIDTH + 3;
  localparam int WP = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int RP = DATA_WIDTH + 2;
  logic [AP-1:0] aw_q, ar_q;
  logic [WP-1:0] w_q;
  logic [1:0]    b_q;
  logic [RP-1:0] r_q;
  assign {M_AXI_awprot, M_AXI_awaddr} = aw_q;
  assign {M_AXI_wstrb, M_AXI_wdata}   = w_q;
  assign S_AXI_bresp                  = b_q;
  assign {M_AXI_arprot, M_AXI_araddr} = ar_q;
  assign {S_AXI_rresp, S_AXI_rdata}   = r_q;
  axi4lite_reg_slice_skid #(.W(AP)) u_aw (
    .clk, .resetn,
    .src_valid(S_AXI_awvalid), .src_ready(S_AXI_awready), .src_data({S_AXI_awprot, S_AXI_awaddr}),
    .dst_valid(M_AXI_awvalid), .dst_ready(M_AXI_awready), .dst_data(aw_q)
  );
  axi4lite_reg_slice_skid #(.W(WP)) u_w (
    .clk, .resetn,
    .src_valid(S_AXI_wvalid), .src_ready(S_AXI_wready), .src_data({S_AXI_wstrb, S_AXI_wdata}),
    .dst_valid(M_AXI_wvalid), .dst_ready(M_AXI_wready), .dst_data(w_q)
  );
  axi4lite_reg_slice_skid #(.W(2)) u_b (
    .clk, .resetn,
    .src_valid(M_AXI_bvalid), .src_ready(M_AXI_bready), .src_data(M_AXI_bresp),
    .dst_valid(S_AXI_bvalid), .dst_ready(S_AXI_bready), .dst_data(b_q)
  );
  axi4lite_reg_slice_skid #(.W(AP)) u_ar (
    .clk, .resetn,
    .src_valid(S_AXI_arvalid), .src_ready(S_AXI_arready), .src_data({S_AXI_arprot, S_AXI_araddr}),
    .dst_valid(M_AXI_arvalid), .dst_ready(M_AXI_arready), .dst_data(ar_q)
  );
  axi4lite_reg_slice_skid #(.W(RP)) u_r (
    .clk, .resetn,
    .src_valid(M_AXI_rvalid), .src_ready(M_AXI_rready), .src_data({M_AXI_rresp, M_AXI_rdata}),
    .dst_valid(S_AXI_rvalid), .dst_ready(S_AXI_rready), .dst_data(r_q)
  );
endmodule
